// File: rtl/player_cmd_sequencer.sv
// Keypad-to-engine command sequencer: debounces five keys, arbitrates directions,
// generates hold-to-repeat moves and cooled-down bombs on a valid/ready channel.
module player_cmd_sequencer #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_RATE   = 20000,
  parameter int BOMB_COOLDOWN = 100000,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       action,
  input  logic       enable,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready
);

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_UP    = 3'd1;
  localparam logic [2:0] CODE_DOWN  = 3'd2;
  localparam logic [2:0] CODE_LEFT  = 3'd3;
  localparam logic [2:0] CODE_RIGHT = 3'd4;
  localparam logic [2:0] CODE_BOMB  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(BOMB_COOLDOWN);

  localparam int NKEYS   = 5;
  localparam int KEY_ACT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } move_state_t;

  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_db_q, key_db_d;
  logic [CNT_W-1:0] db_cnt_q [NKEYS];
  logic [CNT_W-1:0] db_cnt_d [NKEYS];

  logic [2:0]       sel_dir;

  move_state_t      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       move_code_q, move_code_d;
  logic             move_issue;

  logic             action_prev_q, action_prev_d;
  logic             bomb_req;
  logic [CNT_W-1:0] cooldown_q, cooldown_d;

  logic             move_pend_q, move_pend_d;
  logic             bomb_pend_q, bomb_pend_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       cmd_code_q, cmd_code_d;
  logic             out_load;

  assign key_raw = {action, right, left, down, up};

  // A key only flips after its raw level has disagreed for DB_CYCLES straight cycles.
  always_comb begin
    key_db_d = key_db_q;
    for (int i = 0; i < NKEYS; i++) begin
      db_cnt_d[i] = '0;
      if (key_raw[i] != key_db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          key_db_d[i] = key_raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_db_q <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      key_db_q <= key_db_d;
      for (int i = 0; i < NKEYS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  always_comb begin
    sel_dir = CODE_NONE;
    if (key_db_q[0]) begin
      sel_dir = CODE_UP;
    end else if (key_db_q[1]) begin
      sel_dir = CODE_DOWN;
    end else if (key_db_q[2]) begin
      sel_dir = CODE_LEFT;
    end else if (key_db_q[3]) begin
      sel_dir = CODE_RIGHT;
    end
  end

  // move_code_q doubles as the latched direction the repeat timer belongs to.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    move_code_d = move_code_q;
    move_issue  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (sel_dir != CODE_NONE)) begin
          move_issue  = 1'b1;
          move_code_d = sel_dir;
          timer_d     = DELAY_LOAD;
          state_d     = DELAY;
        end
      end
      DELAY, RPT: begin
        if (!enable || (sel_dir != move_code_q)) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          move_issue  = 1'b1;
          move_code_d = sel_dir;
          timer_d     = RATE_LOAD;
          state_d     = RPT;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      move_code_q <= CODE_NONE;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      move_code_q <= move_code_d;
    end
  end

  // Edges arriving while the cooldown runs are dropped rather than queued.
  always_comb begin
    action_prev_d = key_db_q[KEY_ACT];
    bomb_req      = key_db_q[KEY_ACT] && !action_prev_q && enable && (cooldown_q == '0);
    cooldown_d    = cooldown_q;
    if (cmd_valid_q && cmd_ready && (cmd_code_q == CODE_BOMB)) begin
      cooldown_d = COOL_LOAD;
    end else if (cooldown_q != '0) begin
      cooldown_d = cooldown_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      action_prev_q <= 1'b0;
      cooldown_q    <= '0;
    end else begin
      action_prev_q <= action_prev_d;
      cooldown_q    <= cooldown_d;
    end
  end

  // Setting a flag wins over clearing it on load, so a same-cycle issue shows up next cycle.
  always_comb begin
    out_load    = !cmd_valid_q || cmd_ready;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    bomb_pend_d = bomb_pend_q;
    move_pend_d = move_pend_q;
    if (out_load) begin
      if (bomb_pend_q && enable) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = CODE_BOMB;
        bomb_pend_d = 1'b0;
      end else if (move_pend_q && enable) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = move_code_q;
        move_pend_d = 1'b0;
      end else begin
        cmd_valid_d = 1'b0;
        cmd_code_d  = CODE_NONE;
      end
    end
    if (bomb_req) begin
      bomb_pend_d = 1'b1;
    end
    if (move_issue) begin
      move_pend_d = 1'b1;
    end
    if (!enable) begin
      bomb_pend_d = 1'b0;
      move_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CODE_NONE;
      bomb_pend_q <= 1'b0;
      move_pend_q <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      bomb_pend_q <= bomb_pend_d;
      move_pend_q <= move_pend_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;

endmodule

// File: tb/tb_player_cmd_sequencer.sv
// Directed bench for player_cmd_sequencer: accepted commands are logged with their
// cycle stamp and compared against hand-computed offsets from each case's start.
module tb_player_cmd_sequencer;

  localparam logic [4:0] K_NONE  = 5'b00000;
  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_RIGHT = 5'b01000;
  localparam logic [4:0] K_ACT   = 5'b10000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, action = 1'b0;
  logic       enable = 1'b1;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_code;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int idle_bad = 0;
  int base = 0;
  int ev_cyc[$];
  int ev_code[$];
  int exp_off[$];
  int exp_code[$];

  player_cmd_sequencer #(
    .DB_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(5),
    .BOMB_COOLDOWN(20),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .action(action),
    .enable(enable),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every handshake; also catch a nonzero code while the channel is idle.
  always @(negedge clk) begin
    if (resetn && cmd_valid && cmd_ready) begin
      ev_cyc.push_back(cyc);
      ev_code.push_back(int'(cmd_code));
    end
    if (!cmd_valid && (cmd_code != 3'd0)) idle_bad++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] keys, input logic en, input logic rdy);
    {action, right, left, down, up} = keys;
    enable    = en;
    cmd_ready = rdy;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic startCase();
    ev_cyc.delete();
    ev_code.delete();
    exp_off.delete();
    exp_code.delete();
    base = cyc;
  endtask

  task automatic expectEvent(input int off, input int code);
    exp_off.push_back(off);
    exp_code.push_back(code);
  endtask

  task automatic checkEvents(input string tag);
    int obs_off;
    int obs_code;
    checkOutput({tag, "_count"}, ev_cyc.size(), exp_off.size());
    for (int i = 0; i < exp_off.size(); i++) begin
      obs_off  = (i < ev_cyc.size()) ? ev_cyc[i] - base : -1;
      obs_code = (i < ev_code.size()) ? ev_code[i] : -1;
      checkOutput($sformatf("%s_off%0d", tag, i), obs_off, exp_off[i]);
      checkOutput($sformatf("%s_code%0d", tag, i), obs_code, exp_code[i]);
    end
  endtask

  initial begin
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(3);
    checkOutput("reset_valid", int'(cmd_valid), 0);
    checkOutput("reset_code", int'(cmd_code), 0);
    resetn = 1'b1;

    // Three-cycle glitch never survives the debouncer.
    startCase();
    applyStimulus(K_UP, 1'b1, 1'b1);
    waitCycles(3);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(20);
    checkOutput("glitch_count", ev_cyc.size(), 0);

    // Four cycles is enough: flip after edge 4, command at edge 6.
    startCase();
    applyStimulus(K_UP, 1'b1, 1'b1);
    waitCycles(4);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(20);
    expectEvent(6, 1);
    checkEvents("single_up");

    // Hold-to-repeat: 10-cycle first gap, then every 5, stops once debounced low.
    startCase();
    applyStimulus(K_UP, 1'b1, 1'b1);
    waitCycles(40);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(25);
    expectEvent(6, 1);
    expectEvent(16, 1);
    expectEvent(21, 1);
    expectEvent(26, 1);
    expectEvent(31, 1);
    expectEvent(36, 1);
    expectEvent(41, 1);
    checkEvents("hold_up");

    // Up beats left; releasing up hands over to left with a fresh delay.
    startCase();
    applyStimulus(K_UP | K_LEFT, 1'b1, 1'b1);
    waitCycles(12);
    applyStimulus(K_LEFT, 1'b1, 1'b1);
    waitCycles(23);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(20);
    expectEvent(6, 1);
    expectEvent(16, 1);
    expectEvent(19, 3);
    expectEvent(29, 3);
    expectEvent(34, 3);
    expectEvent(39, 3);
    checkEvents("up_left");

    // Bomb, a press inside the cooldown (dropped), then a press after it.
    startCase();
    applyStimulus(K_ACT, 1'b1, 1'b1);
    waitCycles(6);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(8);
    applyStimulus(K_ACT, 1'b1, 1'b1);
    waitCycles(6);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(10);
    applyStimulus(K_ACT, 1'b1, 1'b1);
    waitCycles(6);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(30);
    expectEvent(6, 5);
    expectEvent(36, 5);
    checkEvents("bomb_cool");

    // Stalled channel: bomb held stable, the repeated rights collapse to one.
    startCase();
    applyStimulus(K_RIGHT | K_ACT, 1'b1, 1'b0);
    waitCycles(10);
    checkOutput("stall_valid_a", int'(cmd_valid), 1);
    checkOutput("stall_code_a", int'(cmd_code), 5);
    waitCycles(15);
    checkOutput("stall_valid_b", int'(cmd_valid), 1);
    checkOutput("stall_code_b", int'(cmd_code), 5);
    waitCycles(5);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(30);
    expectEvent(30, 5);
    expectEvent(31, 4);
    checkEvents("stall");

    // No moves while disabled; enabling with the key held issues at once.
    startCase();
    applyStimulus(K_UP, 1'b0, 1'b1);
    waitCycles(20);
    checkOutput("disabled_count", ev_cyc.size(), 0);
    applyStimulus(K_UP, 1'b1, 1'b1);
    waitCycles(2);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(20);
    expectEvent(22, 1);
    checkEvents("enable_up");

    // Reset in the middle of repeats with a command waiting.
    startCase();
    applyStimulus(K_UP, 1'b1, 1'b0);
    waitCycles(22);
    checkOutput("pre_rst_valid", int'(cmd_valid), 1);
    checkOutput("pre_rst_code", int'(cmd_code), 1);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_valid", int'(cmd_valid), 0);
    checkOutput("mid_rst_code", int'(cmd_code), 0);
    waitCycles(2);
    resetn = 1'b1;
    startCase();
    applyStimulus(K_UP, 1'b1, 1'b1);
    waitCycles(9);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    waitCycles(20);
    expectEvent(6, 1);
    checkEvents("after_rst");

    checkOutput("idle_code_zero", idle_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
